wb_regfile: RTL
===============

# wb_regfile

Architectural integer register file and retirement tracker at the far end of the writeback path. Consumes the registered writeback bundle (data, write enable, destination, pc, instruction) from the LSU/WB pipeline register, commits register writes, and serves two combinational read ports to decode. It also counts retired instructions and presents a one-cycle retirement trace for debug and commit-checking.

## Interface
- XLEN, 32, data width of registers and pc/inst trace
- REG_NUM, 32, number of architectural registers; address width is log2(REG_NUM) = 5
- CNT_W, 64, retirement counter width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset; synchronous, active-low
- wb_reg_wdata  input  XLEN  writeback data
- wb_rd_reg_en  input  1  writeback register write enable
- wb_rd_reg_addr  input  5  writeback destination register
- wb_pc  input  XLEN  pc of instruction in WB
- wb_inst  input  XLEN  instruction word in WB; 32'h0 marks a bubble
- rs1_raddr  input  5  read port 1 address
- rs2_raddr  input  5  read port 2 address
- rs1_rdata  output  XLEN  read port 1 data (combinational)
- rs2_rdata  output  XLEN  read port 2 data (combinational)
- retire_valid  output  1  registered pulse, one instruction retired last cycle
- retire_pc  output  XLEN  pc of retired instruction
- retire_inst  output  XLEN  instruction word of retired instruction
- retire_cnt  output  CNT_W  total retired instructions since reset

## Operation
- Write: on rising clk with rst_n=1, wb_rd_reg_en=1 and wb_rd_reg_addr!=0, regs[wb_rd_reg_addr] <= wb_reg_wdata.
- x0: never written; reads of address 0 always return 0, including under bypass.
- Read: rsN_rdata = regs[rsN_raddr], pure combinational; both ports independent, same address on both allowed.
- Retirement: an instruction retires in the cycle wb_inst != 32'h0. Next edge: retire_valid<=1, retire_pc<=wb_pc, retire_inst<=wb_inst, retire_cnt<=retire_cnt+1. Bubble cycle: retire_valid<=0, retire_pc/retire_inst hold, counter holds.
- Retirement is independent of wb_rd_reg_en (stores/branches retire without writing).
- retire_cnt wraps from all-ones to 0 with no flag.

## Timing
- Write-to-read latency: 1 cycle without bypass (value visible after the write edge); 0 cycles with bypass.
- Retire outputs lag the WB bundle by exactly 1 cycle.
- Reset (synchronous): on edge with rst_n=0, all regs <= 0, retire_valid<=0, retire_pc<=0, retire_inst<=0, retire_cnt<=0. While rst_n=0, rs1_rdata/rs2_rdata forced 0 and bypass disabled; any WB write or retirement presented that cycle is dropped.
- Reset asserted mid-stream: state cleared at that edge regardless of pending writeback; first post-reset write commits on first edge with rst_n=1.
- Write to x0 with wb_rd_reg_en=1: no state change, no bypass.

## Configuration
- WB_REGFILE_BYPASS_EN defined: if wb_rd_reg_en=1, wb_rd_reg_addr!=0, rst_n=1 and rsN_raddr==wb_rd_reg_addr, rsN_rdata = wb_reg_wdata in the same cycle (write-through). Applies to both ports simultaneously.
- Undefined: reads return array contents only; a same-cycle write is visible the next cycle; decode/hazard logic must stall one extra cycle.

## Structure
- Shared package cpu_pkg: XLEN, REG_ADDR_W (5), INST_BUBBLE (32'h0), CNT_W default.
- One sub-module regfile_bank: storage array, write port, two raw read ports, x0 masking. Bypass mux, reset gating of reads and retirement tracker live in wb_regfile.

## Test plan
- Reset then read all 32 addresses on both ports -> all 0; retire_cnt=0, retire_valid=0.
- Write x5=32'hDEADBEEF, next cycle read rs1=5, rs2=5 -> both 32'hDEADBEEF; write x0=32'h1234 -> x0 reads 0.
- Same cycle write x7=32'hA5A5A5A5 and read rs1=7 -> bypass build: 32'hA5A5A5A5 same cycle; non-bypass build: old value, new value next cycle.
- Feed 3 instructions (pc 0x100,0x104,0x108, nonzero inst) with one bubble between 2nd and 3rd -> retire_valid pattern 1,1,0,1; retire_cnt 1,2,2,3; retire_pc tracks, holds 0x104 through bubble.
- Preload retire_cnt near wrap (force 64'hFFFF_FFFF_FFFF_FFFF), retire one -> retire_cnt=0.
- Assert rst_n=0 for one cycle during back-to-back writes to x3 -> x3 reads 0 after reset, rdata forced 0 during reset, retire_cnt=0, next write commits normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the writeback register file.
// Optional macro: WB_REGFILE_BYPASS_EN (used by wb_regfile).
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 64;

    localparam logic [XLEN-1:0] INST_BUBBLE = 32'h0;

    typedef logic [XLEN-1:0]       xlen_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic  valid;
        xlen_t pc;
        xlen_t inst;
    } retire_t;

endpackage

// File: rtl/wb_regfile_if.sv
// Writeback bundle, decode read ports and retirement trace.
// master = pipeline/decode side, slave = register file side.
interface wb_regfile_if #(
    parameter int CNT_W = cpu_pkg::CNT_W
);
    import cpu_pkg::*;

    xlen_t      wb_reg_wdata;
    logic       wb_rd_reg_en;
    reg_addr_t  wb_rd_reg_addr;
    xlen_t      wb_pc;
    xlen_t      wb_inst;
    reg_addr_t  rs1_raddr;
    reg_addr_t  rs2_raddr;
    xlen_t      rs1_rdata;
    xlen_t      rs2_rdata;
    logic       retire_valid;
    xlen_t      retire_pc;
    xlen_t      retire_inst;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr,
        output wb_pc, wb_inst, rs1_raddr, rs2_raddr,
        input  rs1_rdata, rs2_rdata,
        input  retire_valid, retire_pc, retire_inst, retire_cnt
    );

    modport slave (
        input  wb_reg_wdata, wb_rd_reg_en, wb_rd_reg_addr,
        input  wb_pc, wb_inst, rs1_raddr, rs2_raddr,
        output rs1_rdata, rs2_rdata,
        output retire_valid, retire_pc, retire_inst, retire_cnt
    );

endinterface

// File: rtl/wb_regfile_bank.sv
// Register storage: one write port, two raw read ports.
// x0 is never written and always reads as zero.
module regfile_bank
    import cpu_pkg::*;
#(
    parameter int NUM = REG_NUM
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      we,
    input  reg_addr_t waddr,
    input  xlen_t     wdata,
    input  reg_addr_t raddr1,
    input  reg_addr_t raddr2,
    output xlen_t     rdata1,
    output xlen_t     rdata2
);

    xlen_t regs [NUM];

    // Clear on reset, otherwise commit non-x0 writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file plus retirement tracker at end of WB.
// Optional macro: WB_REGFILE_BYPASS_EN enables same-cycle write-through.
module wb_regfile
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);

    xlen_t   bank_rd1;
    xlen_t   bank_rd2;
    xlen_t   rd1;
    xlen_t   rd2;
    retire_t ret_q;
    logic [$bits(bus.retire_cnt)-1:0] cnt_q;

    regfile_bank u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bus.wb_rd_reg_en),
        .waddr  (bus.wb_rd_reg_addr),
        .wdata  (bus.wb_reg_wdata),
        .raddr1 (bus.rs1_raddr),
        .raddr2 (bus.rs2_raddr),
        .rdata1 (bank_rd1),
        .rdata2 (bank_rd2)
    );

`ifdef WB_REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live = bus.wb_rd_reg_en && (bus.wb_rd_reg_addr != '0);
`endif

    // Read mux: optional write-through, then forced zero during reset.
    always_comb begin
        rd1 = bank_rd1;
        rd2 = bank_rd2;
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_live && bus.rs1_raddr == bus.wb_rd_reg_addr) begin
            rd1 = bus.wb_reg_wdata;
        end
        if (wr_live && bus.rs2_raddr == bus.wb_rd_reg_addr) begin
            rd2 = bus.wb_reg_wdata;
        end
`endif
        if (!rst_n) begin
            rd1 = '0;
            rd2 = '0;
        end
    end

    // Retirement trace: pulse per non-bubble instruction, pc/inst hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ret_q <= '0;
            cnt_q <= '0;
        end else if (bus.wb_inst != INST_BUBBLE) begin
            ret_q.valid <= 1'b1;
            ret_q.pc    <= bus.wb_pc;
            ret_q.inst  <= bus.wb_inst;
            cnt_q       <= cnt_q + 1'b1;
        end else begin
            ret_q.valid <= 1'b0;
        end
    end

    assign bus.rs1_rdata    = rd1;
    assign bus.rs2_rdata    = rd2;
    assign bus.retire_valid = ret_q.valid;
    assign bus.retire_pc    = ret_q.pc;
    assign bus.retire_inst  = ret_q.inst;
    assign bus.retire_cnt   = cnt_q;

endmodule
